popcount_accum_threshold: RTL and testbench

Downstream consumer of the 128-input XNOR-popcount stage's registered 8-bit `sum_ext`. It accumulates one popcount per 128-bit chunk over a programmable number of chunks to form the full binary-neuron dot-product count. It then compares the total against a programmable threshold and emits one activation bit per neuron over a valid/ready handshake. It turns the raw popcount tree into a complete BNN neuron and feeds the activation packer.

---
 rtl/bnn_pkg.sv | 15 +
 rtl/popcount_accum_threshold.sv | 102 ++++++++++
 tb/tb_popcount_accum_threshold.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/bnn_pkg.sv
// Shared BNN constants and types, used by the popcount accumulator and the activation packer.
package bnn_pkg;

    localparam int POP_MAX        = 128;
    localparam int DEF_POP_W      = 8;
    localparam int DEF_MAX_CHUNKS = 64;
    localparam int DEF_ACC_W      = 14;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        EMIT
    } state_t;

endpackage

// File: rtl/popcount_accum_threshold.sv
// Accumulates per-chunk XNOR popcounts into a full neuron count, thresholds it,
// and emits one activation bit per neuron over valid/ready.
module popcount_accum_threshold
    import bnn_pkg::*;
#(
    parameter int POP_W      = DEF_POP_W,
    parameter int MAX_CHUNKS = DEF_MAX_CHUNKS,
    parameter int CNT_W      = $clog2(MAX_CHUNKS),
    parameter int ACC_W      = POP_W + CNT_W,
    parameter int IDX_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [CNT_W-1:0] cfg_chunks,
    input  logic [ACC_W-1:0] cfg_thresh,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [POP_W-1:0] in_pop,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_bit,
    output logic [ACC_W-1:0] out_sum,
    output logic [IDX_W-1:0] out_idx,
    output logic             err_pop
);

    localparam logic [POP_W-1:0] POP_LIM    = POP_W'(POP_MAX);
    localparam logic [CNT_W:0]   CNT_FULL   = (CNT_W+1)'(MAX_CHUNKS);

    state_t             state, state_nxt;
    logic [ACC_W-1:0]   acc, thr;
    logic [CNT_W-1:0]   chunk_cnt, n_chunks;

    logic [POP_W-1:0]   pop_c;
    logic               accept, first, last;
    logic [ACC_W-1:0]   acc_base, acc_new, thr_eff;
    logic [CNT_W-1:0]   cnt_base, n_eff;
    logic [CNT_W:0]     cnt_new, n_target;

    // Gated by rst_n so the upstream sees no ready while reset is held.
    assign in_ready  = rst_n && ((state == EMIT) ? out_ready : 1'b1);
    assign out_valid = (state == EMIT);

    always_comb begin
        pop_c    = (in_pop > POP_LIM) ? POP_LIM : in_pop;
        accept   = in_valid && in_ready;
        // Outside ACCUM an accepted chunk opens a new neuron with fresh config.
        first    = (state != ACCUM);
        acc_base = first ? '0 : acc;
        cnt_base = first ? '0 : chunk_cnt;
        n_eff    = first ? cfg_chunks : n_chunks;
        thr_eff  = first ? cfg_thresh : thr;
        acc_new  = acc_base + ACC_W'(pop_c);
        cnt_new  = {1'b0, cnt_base} + (CNT_W+1)'(1);
        n_target = (n_eff == '0) ? CNT_FULL : {1'b0, n_eff};
        last     = (cnt_new == n_target);

        state_nxt = state;
        case (state)
            IDLE, ACCUM: if (accept) state_nxt = last ? EMIT : ACCUM;
            EMIT:        if (out_ready) state_nxt = accept ? (last ? EMIT : ACCUM) : IDLE;
            default:     state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc       <= '0;
            thr       <= '0;
            chunk_cnt <= '0;
            n_chunks  <= '0;
            out_bit   <= 1'b0;
            out_sum   <= '0;
            out_idx   <= '0;
            err_pop   <= 1'b0;
        end else begin
            if (accept && (in_pop > POP_LIM)) err_pop <= 1'b1;
            if (accept) begin
                if (first) begin
                    n_chunks <= cfg_chunks;
                    thr      <= cfg_thresh;
                end
                if (last) begin
                    out_sum   <= acc_new;
                    out_bit   <= (acc_new >= thr_eff);
                    acc       <= '0;
                    chunk_cnt <= '0;
                end else begin
                    acc       <= acc_new;
                    chunk_cnt <= cnt_new[CNT_W-1:0];
                end
            end
            if (out_valid && out_ready) out_idx <= out_idx + IDX_W'(1);
        end
    end

endmodule

// File: tb/tb_popcount_accum_threshold.sv
// Directed bench for popcount_accum_threshold with hand-computed expectations.
module tb_popcount_accum_threshold;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [5:0]  cfg_chunks;
    logic [13:0] cfg_thresh;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_pop;
    logic        out_valid;
    logic        out_ready;
    logic        out_bit;
    logic [13:0] out_sum;
    logic [15:0] out_idx;
    logic        err_pop;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    popcount_accum_threshold dut (
        .clk(clk), .rst_n(rst_n), .cfg_chunks(cfg_chunks), .cfg_thresh(cfg_thresh),
        .in_valid(in_valid), .in_ready(in_ready), .in_pop(in_pop),
        .out_valid(out_valid), .out_ready(out_ready), .out_bit(out_bit),
        .out_sum(out_sum), .out_idx(out_idx), .err_pop(err_pop)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_pop = '0; out_ready = 1'b1;
        cfg_chunks = 6'd1; cfg_thresh = 14'd0;
        step(); step();
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (out_sum !== 14'd0 || out_bit !== 1'b0) begin errors++; $display("FAIL reset_out_sum got=%0d/%b exp=0/0", out_sum, out_bit); end
        checks++; if (out_idx !== 16'd0 || err_pop !== 1'b0) begin errors++; $display("FAIL reset_idx_err got=%0d/%b exp=0/0", out_idx, err_pop); end
        rst_n = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_single_chunk();
        cfg_chunks = 6'd1; cfg_thresh = 14'd64; out_ready = 1'b1;
        in_valid = 1'b1; in_pop = 8'd64;
        step();
        checks++; if (out_valid !== 1'b1 || out_sum !== 14'd64 || out_bit !== 1'b1 || out_idx !== 16'd0) begin
            errors++; $display("FAIL single_first got v=%b s=%0d b=%b i=%0d exp 1/64/1/0", out_valid, out_sum, out_bit, out_idx); end
        in_pop = 8'd63;
        step();
        checks++; if (out_valid !== 1'b1 || out_sum !== 14'd63 || out_bit !== 1'b0 || out_idx !== 16'd1) begin
            errors++; $display("FAIL single_second got v=%b s=%0d b=%b i=%0d exp 1/63/0/1", out_valid, out_sum, out_bit, out_idx); end
        in_valid = 1'b0;
        step();
        checks++; if (out_valid !== 1'b0 || out_idx !== 16'd2) begin
            errors++; $display("FAIL single_drain got v=%b i=%0d exp 0/2", out_valid, out_idx); end
    endtask

    task automatic test_full_length();
        cfg_chunks = 6'd0; cfg_thresh = 14'd8192; out_ready = 1'b1;
        in_valid = 1'b1; in_pop = 8'd128;
        for (int i = 0; i < 63; i++) step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL full_early_valid got=%b exp=0", out_valid); end
        step();
        checks++; if (out_valid !== 1'b1 || out_sum !== 14'd8192 || out_bit !== 1'b1 || out_idx !== 16'd2) begin
            errors++; $display("FAIL full_thr8192 got v=%b s=%0d b=%b i=%0d exp 1/8192/1/2", out_valid, out_sum, out_bit, out_idx); end
        cfg_thresh = 14'd8193;
        for (int i = 0; i < 64; i++) step();
        checks++; if (out_valid !== 1'b1 || out_sum !== 14'd8192 || out_bit !== 1'b0 || out_idx !== 16'd3) begin
            errors++; $display("FAIL full_thr8193 got v=%b s=%0d b=%b i=%0d exp 1/8192/0/3", out_valid, out_sum, out_bit, out_idx); end
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_backpressure();
        cfg_chunks = 6'd3; cfg_thresh = 14'd50; out_ready = 1'b0;
        in_valid = 1'b1;
        in_pop = 8'd10; step();
        in_pop = 8'd20; step();
        in_pop = 8'd30; step();
        checks++; if (out_valid !== 1'b1 || out_sum !== 14'd60 || out_bit !== 1'b1 || out_idx !== 16'd4) begin
            errors++; $display("FAIL bp_result got v=%b s=%0d b=%b i=%0d exp 1/60/1/4", out_valid, out_sum, out_bit, out_idx); end
        in_pop = 8'd99;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++; if (out_valid !== 1'b1 || out_sum !== 14'd60 || in_ready !== 1'b0 || out_idx !== 16'd4) begin
                errors++; $display("FAIL bp_hold cyc=%0d got v=%b s=%0d r=%b i=%0d exp 1/60/0/4", i, out_valid, out_sum, in_ready, out_idx); end
        end
        in_valid = 1'b0; out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_follow got=%b exp=1", in_ready); end
        step();
        checks++; if (out_valid !== 1'b0 || out_idx !== 16'd5) begin
            errors++; $display("FAIL bp_handshake got v=%b i=%0d exp 0/5", out_valid, out_idx); end
    endtask

    task automatic test_cfg_change();
        cfg_chunks = 6'd4; cfg_thresh = 14'd0; out_ready = 1'b1;
        in_valid = 1'b1; in_pop = 8'd1;
        step();
        cfg_chunks = 6'd2;
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL cfg_early_valid got=%b exp=0", out_valid); end
        step(); step();
        checks++; if (out_valid !== 1'b1 || out_sum !== 14'd4 || out_idx !== 16'd5) begin
            errors++; $display("FAIL cfg_result got v=%b s=%0d i=%0d exp 1/4/5", out_valid, out_sum, out_idx); end
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_clamp();
        checks++; if (err_pop !== 1'b0) begin errors++; $display("FAIL clamp_pre_err got=%b exp=0", err_pop); end
        cfg_chunks = 6'd1; cfg_thresh = 14'd128; out_ready = 1'b1;
        in_valid = 1'b1; in_pop = 8'd200;
        step();
        checks++; if (out_valid !== 1'b1 || out_sum !== 14'd128 || out_bit !== 1'b1 || err_pop !== 1'b1) begin
            errors++; $display("FAIL clamp_result got v=%b s=%0d b=%b e=%b exp 1/128/1/1", out_valid, out_sum, out_bit, err_pop); end
        in_valid = 1'b0;
        step(); step();
        checks++; if (err_pop !== 1'b1 || out_idx !== 16'd7) begin
            errors++; $display("FAIL clamp_sticky got e=%b i=%0d exp 1/7", err_pop, out_idx); end
    endtask

    task automatic test_reset_mid();
        cfg_chunks = 6'd4; cfg_thresh = 14'd3; out_ready = 1'b1;
        in_valid = 1'b1; in_pop = 8'd1;
        step(); step();
        in_valid = 1'b0; rst_n = 1'b0;
        step();
        checks++; if (err_pop !== 1'b0 || out_idx !== 16'd0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL mid_reset got e=%b i=%0d v=%b exp 0/0/0", err_pop, out_idx, out_valid); end
        rst_n = 1'b1; in_valid = 1'b1;
        step(); step(); step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_early_valid got=%b exp=0", out_valid); end
        step();
        checks++; if (out_valid !== 1'b1 || out_sum !== 14'd4 || out_bit !== 1'b1 || out_idx !== 16'd0) begin
            errors++; $display("FAIL mid_result got v=%b s=%0d b=%b i=%0d exp 1/4/1/0", out_valid, out_sum, out_bit, out_idx); end
        in_valid = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_single_chunk();
        test_full_length();
        test_backpressure();
        test_cfg_change();
        test_clamp();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
